// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor: opcodes,
// fetch FSM encoding and address width.
package proc_pkg;

  localparam int ADDR_W = 4;

  localparam logic [3:0] HALT_OP   = 4'd0;
  localparam logic [3:0] SOMA      = 4'd1;
  localparam logic [3:0] SUBTRACAO = 4'd2;
  localparam logic [3:0] MULT      = 4'd3;
  localparam logic [3:0] DIV       = 4'd4;
  localparam logic [3:0] AND       = 4'd5;
  localparam logic [3:0] OR        = 4'd6;
  localparam logic [3:0] XOR       = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM latency absorption and
// valid/ready issue of opcodes to the execute stage.
module fetch_unit #(
  parameter int         PROG_LEN = 16,
  parameter logic [3:0] HALT_OP  = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] addr_p,
  input  logic [3:0] out_prom,
  output logic [3:0] instr,
  output logic       instr_valid,
  input  logic       exec_ready,
  output logic       busy,
  output logic       halted
);
  import proc_pkg::*;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(PROG_LEN - 1);

  fetch_state_t state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0] instr_d;
  logic valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_p      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      addr_p      <= addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr_p;
    instr_d = instr;
    valid_d = instr_valid;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // ROM output now reflects addr_p registered last edge
        if (out_prom == HALT_OP) begin
          state_d = S_HALTED;
        end else begin
          instr_d = out_prom;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_ready) begin
          valid_d = 1'b0;
          if (addr_p == LAST) begin
            state_d = S_HALTED;
          end else begin
            addr_d  = addr_p + 4'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state == S_FETCH) ||
                  (state == S_LATCH) ||
                  (state == S_ISSUE);
  assign halted = (state == S_HALTED);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 4-bit processor.
- Holds the program counter and drives the address input (addr_p) of program_rom.
- Absorbs the ROM's one-cycle registered-address read latency and captures the returned opcode (out_prom).
- Presents the opcode to the execute/decode stage over a valid/ready handshake and stops on a halt opcode or at program end.

Parameters:
- PROG_LEN, 16: number of program words; last fetched address is PROG_LEN-1. Legal range 1..16.
- HALT_OP, 4'b0000: opcode that terminates the program. It is never issued.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin program from address 0. Honoured only in IDLE or HALTED.
- addr_p, output, 4: program counter, wired to program_rom addr_p.
- out_prom, input, 4: opcode returned by program_rom.
- instr, output, 4: captured opcode for the execute stage.
- instr_valid, output, 1: instr holds an unconsumed opcode.
- exec_ready, input, 1: execute stage accepts instr this cycle.
- busy, output, 1: high in FETCH, LATCH and ISSUE.
- halted, output, 1: high in HALTED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - addr_p=0, instr=0, instr_valid=0, busy=0, halted=0.
  - Release is synchronous to the next clk edge.
- All outputs are registered or decoded from the state register. out_prom is never passed combinationally to instr.
- FSM states: IDLE, FETCH, LATCH, ISSUE, HALTED.
- IDLE:
  - start=1 -> addr_p<=0, go FETCH. Otherwise stay.
- FETCH:
  - addr_p is stable for the whole cycle, so the ROM registers it at the closing edge.
  - Unconditionally go LATCH.
- LATCH:
  - out_prom is valid for addr_p.
  - out_prom==HALT_OP -> go HALTED. instr and instr_valid unchanged (instr_valid stays 0).
  - Otherwise instr<=out_prom, instr_valid<=1, go ISSUE.
- ISSUE:
  - instr_valid=1; instr is held stable until the handshake.
  - exec_ready=0 -> stay, no change.
  - exec_ready=1 (transfer at this edge) -> instr_valid<=0, then:
    - addr_p==PROG_LEN-1 -> go HALTED, addr_p unchanged.
    - Otherwise addr_p<=addr_p+1, go FETCH.
- HALTED:
  - halted=1, addr_p holds its last value.
  - start=1 -> addr_p<=0, go FETCH (restart).
- Latency and throughput:
  - start sampled at edge k -> instr_valid high from cycle k+3.
  - Each accepted instruction to next instr_valid: 3 cycles.
  - Peak throughput is 1 instruction per 3 cycles.
- Width rules:
  - addr_p increments modulo 16 internally, but wrap never occurs: PROG_LEN-1 is checked before incrementing.
  - PROG_LEN=16 stops after address 15.
- Boundary conditions:
  - start in FETCH, LATCH or ISSUE: ignored.
  - exec_ready high outside ISSUE: ignored.
  - exec_ready held high continuously: one transfer per ISSUE visit.
  - HALT_OP at address 0: HALTED after 2 cycles, no instruction issued.
  - PROG_LEN=1: one instruction issued, then HALTED.
  - Reset mid-ISSUE: instr_valid drops immediately (asynchronous), pending instruction discarded, IDLE.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode constants: SOMA=1, SUBTRACAO=2, MULT=3, DIV=4, AND=5, OR=6, XOR=7, HALT_OP=0.
  - Fetch FSM state encoding.
  - Address width constant (4).
- program_rom and the decoder take opcode values from proc_pkg.
- No sub-module. The PC register and FSM are a single block.
- A top-level wrapper ties fetch_unit.addr_p to program_rom.addr_p and program_rom.out_prom back to fetch_unit.out_prom.

Test Plan:
- Reset mid-run: assert rst_n=0 during ISSUE -> same cycle instr_valid=0, addr_p=0, busy=0. After release with start=0, stays IDLE.
- Basic fetch:
  - Setup: ROM {1,2,3,4,0,...}, exec_ready=1, start pulsed at edge k.
  - Required: instr_valid first high in cycle k+3 with instr=1.
  - Then 2,3,4 issued at 3-cycle spacing, then HALTED with addr_p=4; opcode 0 never issued.
- Backpressure:
  - Stimulus: hold exec_ready=0 for 5 cycles in ISSUE with instr=2.
  - Required: instr=2 and instr_valid=1 stable throughout, addr_p unchanged. Raising exec_ready gives exactly one transfer, and addr_p advances by 1.
- Program end: ROM all 7 (XOR), PROG_LEN=16 -> 16 transfers at addresses 0..15, then HALTED with addr_p=15, no wrap to 0.
- Restart and ignored start: pulse start in HALTED -> FETCH with addr_p=0, and the sequence repeats identically. A start pulse during LATCH changes nothing.
- Immediate halt: ROM[0]=0 -> halted=1 two cycles after FETCH entry, instr_valid never asserted.
